// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Definitions shared by the clock-setting controller and the timekeeper:
// field widths, maximum field values, the controller state encoding and
// wrap-around increment helpers for the hour and minute fields.
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

  // The encoding is visible on the mode output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } clk_state_e;

  // Hour + 1, wrapping 23 -> 0 (values above 23 also fold back to 0).
  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
    return (h >= MAX_HOUR) ? 5'd0 : (h + 5'd1);
  endfunction

  // Minute + 1, wrapping 59 -> 0 (values above 59 also fold back to 0).
  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
    return (m >= MAX_MIN) ? 6'd0 : (m + 6'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes one raw push button into the clk domain, accepts a new level
// only after the synchronized signal has been stable for DEBOUNCE_CYC
// consecutive cycles, and emits a one-cycle press event on each accepted
// 0->1 transition.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_btn    in   raw asynchronous button, high = pressed
//   o_press  out  one-cycle press event (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int             CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;   // previous synchronized sample, for stability test
  logic [2:0]    r_vld;     // marks which pipeline stages hold real samples
  logic [CW-1:0] r_cnt;     // run length of the current synchronized level
  logic          r_level;   // debounced level
  logic          r_armed;   // set once a debounced low is seen after reset
  logic          r_press;

  logic          w_same;
  logic [CW-1:0] w_run_len;
  logic          w_accept;
  logic          w_press;

  // Run-length of the synchronized level including the current cycle.
  // Samples still carrying reset values do not count, so a button held
  // through reset cannot be mistaken for a stable low.
  always_comb begin
    w_same = r_vld[2] && (r_sync2 == r_sync3);
    if (!r_vld[1]) begin
      w_run_len = '0;
    end else if (!w_same) begin
      w_run_len = CW'(1'b1);
    end else if (r_cnt == CNT_MAX) begin
      w_run_len = CNT_MAX;
    end else begin
      w_run_len = r_cnt + CW'(1'b1);
    end
    w_accept = (w_run_len == CNT_MAX);
    // A press needs an accepted rising level and a prior accepted low.
    w_press  = w_accept && r_sync2 && !r_level && r_armed;
  end

  // Synchronizer, run-length counter, debounced level and press event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_vld   <= 3'b000;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_vld   <= {r_vld[1:0], 1'b1};
      r_cnt   <= w_run_len;
      r_press <= w_press;
      if (w_accept) begin
        r_level <= r_sync2;
        if (!r_sync2) begin
          r_armed <= 1'b1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Two-button time-setting controller. A mode press walks RUN -> SET_HOUR ->
// SET_MIN -> COMMIT -> RUN; inc presses advance the field being edited.
// COMMIT emits a one-cycle load pulse to the timekeeper. An edit with no
// press for TIMEOUT_S tick_1hz pulses is abandoned without loading.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   tick_1hz                 1 Hz one-cycle pulse
//   btn_mode, btn_inc        raw push buttons
//   cur_hour, cur_min        live time, captured when an edit starts
//   run_en                   timekeeper advance enable
//   load, load_hour/min/sec  one-cycle load request and its values
//   edit_hour, edit_min      values being edited
//   blank_hour, blank_min    blink blanking for the field being edited
//   mode                     current state encoding
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TIMEOUT_S    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  output logic              run_en,
  output logic              load,
  output logic [HOUR_W-1:0] load_hour,
  output logic [MIN_W-1:0]  load_min,
  output logic [SEC_W-1:0]  load_sec,
  output logic [HOUR_W-1:0] edit_hour,
  output logic [MIN_W-1:0]  edit_min,
  output logic              blank_hour,
  output logic              blank_min,
  output logic [1:0]        mode
);

  localparam int            TW        = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_S - 1);

  logic w_mode_press;
  logic w_inc_press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_mode),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_inc),
    .o_press (w_inc_press)
  );

  clk_state_e        r_state;
  logic [HOUR_W-1:0] r_edit_hour;
  logic [MIN_W-1:0]  r_edit_min;
  logic [TW-1:0]     r_tick_cnt;
  logic              r_phase;
  logic              r_run_en;
  logic              r_load;
  logic [HOUR_W-1:0] r_load_hour;
  logic [MIN_W-1:0]  r_load_min;
  logic              r_blank_hour;
  logic              r_blank_min;

  clk_state_e        w_state_nxt;
  logic [HOUR_W-1:0] w_edit_hour_nxt;
  logic [MIN_W-1:0]  w_edit_min_nxt;
  logic [TW-1:0]     w_tick_nxt;
  logic              w_phase_nxt;
  logic              w_timeout;
  logic              w_in_edit;
  logic              w_entry;

  // State transitions and edit-field updates; mode wins over inc.
  always_comb begin
    w_state_nxt     = r_state;
    w_edit_hour_nxt = r_edit_hour;
    w_edit_min_nxt  = r_edit_min;
    w_timeout       = tick_1hz && (r_tick_cnt == TICK_LAST);
    case (r_state)
      ST_RUN: begin
        if (w_mode_press) begin
          w_state_nxt     = ST_SET_HOUR;
          w_edit_hour_nxt = cur_hour;
          w_edit_min_nxt  = cur_min;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SET_HOUR: begin
        if (w_mode_press) begin
          w_state_nxt = ST_SET_MIN;
        end else if (w_inc_press) begin
          w_edit_hour_nxt = hour_inc(r_edit_hour);
        end else if (w_timeout) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_SET_HOUR;
        end
      end
      ST_SET_MIN: begin
        if (w_mode_press) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_inc_press) begin
          w_edit_min_nxt = min_inc(r_edit_min);
        end else if (w_timeout) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_SET_MIN;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Inactivity counter and blink phase: both restart on entering an edit
  // state and are held at zero outside the edit states.
  always_comb begin
    w_in_edit = (w_state_nxt == ST_SET_HOUR) || (w_state_nxt == ST_SET_MIN);
    w_entry   = w_in_edit && (w_state_nxt != r_state);
    if (!w_in_edit) begin
      w_tick_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (w_entry) begin
      w_tick_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else begin
      if (w_mode_press || w_inc_press) begin
        w_tick_nxt = '0;
      end else if (tick_1hz) begin
        w_tick_nxt = r_tick_cnt + TW'(1'b1);
      end else begin
        w_tick_nxt = r_tick_cnt;
      end
      w_phase_nxt = tick_1hz ? !r_phase : r_phase;
    end
  end

  // State, edit fields and the registered outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_edit_hour  <= 5'd0;
      r_edit_min   <= 6'd0;
      r_tick_cnt   <= '0;
      r_phase      <= 1'b0;
      r_run_en     <= 1'b1;
      r_load       <= 1'b0;
      r_load_hour  <= 5'd0;
      r_load_min   <= 6'd0;
      r_blank_hour <= 1'b0;
      r_blank_min  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_edit_hour  <= w_edit_hour_nxt;
      r_edit_min   <= w_edit_min_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_phase      <= w_phase_nxt;
      r_run_en     <= (w_state_nxt == ST_RUN);
      r_load       <= (w_state_nxt == ST_COMMIT);
      r_load_hour  <= (w_state_nxt == ST_COMMIT) ? w_edit_hour_nxt : 5'd0;
      r_load_min   <= (w_state_nxt == ST_COMMIT) ? w_edit_min_nxt  : 6'd0;
      r_blank_hour <= (w_state_nxt == ST_SET_HOUR) && w_phase_nxt;
      r_blank_min  <= (w_state_nxt == ST_SET_MIN)  && w_phase_nxt;
    end
  end

  assign run_en     = r_run_en;
  assign load       = r_load;
  assign load_hour  = r_load_hour;
  assign load_min   = r_load_min;
  assign load_sec   = 6'd0;
  assign edit_hour  = r_edit_hour;
  assign edit_min   = r_edit_min;
  assign blank_hour = r_blank_hour;
  assign blank_min  = r_blank_min;
  assign mode       = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed scenarios plus randomized button/tick sequences, checked against
// a behavioural model of the clock-setting rules (state, edit fields,
// inactivity count, blink phase, expected loads).
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic       run_en, load, blank_hour, blank_min;
  logic [4:0] load_hour, edit_hour;
  logic [5:0] load_min, load_sec, edit_min;
  logic [1:0] mode;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: 0=RUN 1=SET_HOUR 2=SET_MIN (COMMIT is instantaneous here)
  int m_state, m_hour, m_min, m_cnt, m_phase;
  int exp_q[$];
  int obs_q[$];

  clock_set_ctrl #(.DEBOUNCE_CYC(4), .TIMEOUT_S(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min),
    .run_en(run_en), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .edit_hour(edit_hour), .edit_min(edit_min),
    .blank_hour(blank_hour), .blank_min(blank_min), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Every load pulse is recorded as hhmmss and must coincide with COMMIT.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      obs_q.push_back(int'(load_hour) * 10000 + int'(load_min) * 100 + int'(load_sec));
      chk("load_in_commit", int'(mode), 3);
      chk("load_run_en", int'(run_en), 0);
    end
  end

  task automatic model_reset();
    m_state = 0; m_hour = 0; m_min = 0; m_cnt = 0; m_phase = 0;
  endtask

  task automatic model_press(input bit md, input bit ic);
    if (md) begin
      if (m_state == 0) begin
        m_state = 1; m_hour = int'(cur_hour); m_min = int'(cur_min);
      end else if (m_state == 1) begin
        m_state = 2;
      end else begin
        exp_q.push_back(m_hour * 10000 + m_min * 100);
        m_state = 0;
      end
      m_cnt = 0; m_phase = 0;
    end else if (ic) begin
      if (m_state == 1) begin m_hour = (m_hour + 1) % 24; m_cnt = 0; end
      if (m_state == 2) begin m_min = (m_min + 1) % 60; m_cnt = 0; end
    end
  endtask

  task automatic model_tick();
    if (m_state != 0) begin
      m_cnt++;
      m_phase = 1 - m_phase;
      if (m_cnt >= 3) begin m_state = 0; m_cnt = 0; m_phase = 0; end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit md, input bit ic, input int hold);
    step(1);
    btn_mode = md; btn_inc = ic;
    step(hold);
    btn_mode = 1'b0; btn_inc = 1'b0;
    step(14);
    model_press(md, ic);
  endtask

  task automatic do_tick();
    step(1);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(2);
    model_tick();
  endtask

  task automatic glitch_inc();
    step(1);
    btn_inc = 1'b1;
    step(2);
    btn_inc = 1'b0;
    step(12);
  endtask

  task automatic check_state();
    @(negedge clk);
    chk("mode", int'(mode), m_state);
    chk("run_en", int'(run_en), int'(m_state == 0));
    chk("edit_hour", int'(edit_hour), m_hour);
    chk("edit_min", int'(edit_min), m_min);
    chk("blank_hour", int'(blank_hour), int'(m_state == 1 && m_phase == 1));
    chk("blank_min", int'(blank_min), int'(m_state == 2 && m_phase == 1));
    chk("load_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("load_value", obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    step(3);
    @(negedge clk);
    chk("rst_mode", int'(mode), 0);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_load", int'(load), 0);
    chk("rst_load_hour", int'(load_hour), 0);
    chk("rst_edit_hour", int'(edit_hour), 0);
    chk("rst_blank_hour", int'(blank_hour), 0);
    rst_n = 1'b1;
    step(20);

    // 13:45 -> mode, inc x2, mode, inc x3, mode -> load 15:48:00
    cur_hour = 5'd13; cur_min = 6'd45;
    press(1, 0, 10);
    press(0, 1, 10); press(0, 1, 10);
    press(1, 0, 10);
    press(0, 1, 10); press(0, 1, 10); press(0, 1, 10);
    press(1, 0, 10);
    chk("seq_load_count", obs_q.size(), 1);
    if (obs_q.size() == 1) chk("seq_load_value", obs_q[0], 154800);
    check_state();

    // Field wrap-around
    cur_hour = 5'd23; cur_min = 6'd59;
    press(1, 0, 10);
    press(0, 1, 10);
    check_state();
    chk("hour_wrap", int'(edit_hour), 0);
    press(1, 0, 10);
    press(0, 1, 10);
    check_state();
    chk("min_wrap", int'(edit_min), 0);
    press(1, 0, 10);
    check_state();

    // Simultaneous mode+inc in SET_HOUR: mode wins, hour unchanged
    cur_hour = 5'd7; cur_min = 6'd30;
    press(1, 0, 10);
    press(1, 1, 10);
    check_state();
    chk("both_mode", int'(mode), 2);
    chk("both_hour", int'(edit_hour), 7);

    // Timeout in SET_MIN after three ticks
    do_tick(); do_tick();
    check_state();
    do_tick();
    check_state();
    chk("timeout_run_en", int'(run_en), 1);

    // Glitch ignored, long hold counts once
    press(1, 0, 10);
    glitch_inc();
    check_state();
    press(0, 1, 1000);
    check_state();

    // Reset in SET_MIN takes effect immediately, no load
    press(1, 0, 10);
    check_state();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mode", int'(mode), 0);
    chk("arst_run_en", int'(run_en), 1);
    chk("arst_load", int'(load), 0);
    model_reset();
    step(2);
    rst_n = 1'b1;
    step(20);
    check_state();

    // Button held through reset must not act until re-pressed
    cur_hour = 5'd9; cur_min = 6'd5;
    step(1);
    btn_mode = 1'b1;
    step(14);
    model_press(1, 0);
    check_state();
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    model_reset();
    step(40);
    check_state();
    btn_mode = 1'b0;
    step(14);
    check_state();
    press(1, 0, 10);
    check_state();

    // Randomized sequences
    for (int i = 0; i < 150; i++) begin
      int op;
      cur_hour = 5'($urandom_range(0, 23));
      cur_min  = 6'($urandom_range(0, 59));
      op = int'($urandom_range(0, 9));
      if (op <= 2)      press(1, 0, int'($urandom_range(8, 20)));
      else if (op <= 5) press(0, 1, int'($urandom_range(8, 20)));
      else if (op <= 7) do_tick();
      else if (op == 8) glitch_inc();
      else              press(1, 1, int'($urandom_range(8, 20)));
      check_state();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
